// File: rtl/fdiv_iter_if.sv
// Operand/result handshake bundle for the iterative single-precision divider.
// The divider sits on the slave side; the requester/consumer uses master.
interface fdiv_iter_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] z;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, z
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, z
  );
endinterface

// File: rtl/fdiv_iter.sv
// Multi-cycle IEEE-754 single divider: restoring radix-2 mantissa division, RNE,
// flush-to-zero for denormal inputs and tiny results.
module fdiv_iter #(
  parameter int unsigned ITER = 26
) (
  input logic       clk,
  input logic       rstn,
  fdiv_iter_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDiv   = 2'd1;
  localparam logic [1:0] StRound = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;
  localparam int unsigned CntW   = $clog2(ITER);

  logic [1:0]        state_q, state_d;
  logic              sz_q, sz_d;
  logic signed [9:0] ez_q, ez_d;
  logic [23:0]       my_q, my_d;
  logic [24:0]       rem_q, rem_d;
  logic [ITER-1:0]   q_q, q_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       z_q, z_d;

  // Operand decode, only consumed in the accept cycle
  logic [7:0]        ex, ey;
  logic [23:0]       mx, my;
  logic              x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, sgn;
  logic signed [9:0] ez_acc;

  assign ex     = bus.x[30:23];
  assign ey     = bus.y[30:23];
  assign mx     = {1'b1, bus.x[22:0]};
  assign my     = {1'b1, bus.y[22:0]};
  assign x_nan  = (ex == 8'hFF) && (bus.x[22:0] != 23'd0);
  assign y_nan  = (ey == 8'hFF) && (bus.y[22:0] != 23'd0);
  assign x_inf  = (ex == 8'hFF) && (bus.x[22:0] == 23'd0);
  assign y_inf  = (ey == 8'hFF) && (bus.y[22:0] == 23'd0);
  assign x_zero = (ex == 8'h00);
  assign y_zero = (ey == 8'h00);
  assign sgn    = bus.x[31] ^ bus.y[31];
  assign ez_acc = $signed({2'b00, ex}) - $signed({2'b00, ey}) + 10'sd127;

  // Rounding on the finished quotient: q[25:2] significand, q[1] guard, q[0] round
  logic              sticky, inc;
  logic [24:0]       sig_rnd;
  logic signed [9:0] ez_rnd;

  assign sticky  = |rem_q;
  assign inc     = q_q[1] & (q_q[0] | sticky | q_q[2]);
  assign sig_rnd = {1'b0, q_q[25:2]} + {24'd0, inc};
  // A carry-out leaves bits 22:0 at zero, i.e. significand 1.0 with ez bumped
  assign ez_rnd  = sig_rnd[24] ? ez_q + 10'sd1 : ez_q;

  always_comb begin
    state_d = state_q;
    sz_d    = sz_q;
    ez_d    = ez_q;
    my_d    = my_q;
    rem_d   = rem_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          sz_d  = sgn;
          my_d  = my;
          q_d   = '0;
          cnt_d = '0;
          if (mx < my) begin
            rem_d = {mx, 1'b0};
            ez_d  = ez_acc - 10'sd1;
          end else begin
            rem_d = {1'b0, mx};
            ez_d  = ez_acc;
          end
          if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
            z_d     = 32'h7FC0_0000;
            state_d = StDone;
          end else if (x_inf || y_zero) begin
            z_d     = {sgn, 8'hFF, 23'd0};
            state_d = StDone;
          end else if (x_zero || y_inf) begin
            z_d     = {sgn, 31'd0};
            state_d = StDone;
          end else begin
            state_d = StDiv;
          end
        end
      end
      StDiv: begin
        if (rem_q >= {1'b0, my_q}) begin
          q_d   = {q_q[ITER-2:0], 1'b1};
          rem_d = (rem_q - {1'b0, my_q}) << 1;
        end else begin
          q_d   = {q_q[ITER-2:0], 1'b0};
          rem_d = rem_q << 1;
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(ITER - 1)) begin
          state_d = StRound;
        end
      end
      StRound: begin
        if (ez_rnd >= 10'sd255) begin
          z_d = {sz_q, 8'hFF, 23'd0};
        end else if (ez_rnd <= 10'sd0) begin
          z_d = {sz_q, 31'd0};
        end else begin
          z_d = {sz_q, ez_rnd[7:0], sig_rnd[22:0]};
        end
        state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      sz_q    <= 1'b0;
      ez_q    <= '0;
      my_q    <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      sz_q    <= sz_d;
      ez_q    <= ez_d;
      my_q    <= my_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.z         = z_q;

endmodule
